// File: rtl/mc_controller.sv
// Multi-cycle control unit: FSM sequencing of fetch/decode/memory/execute/branch,
// condition evaluation against the registered NZCV flags, and flag register update.
module mc_controller #(
  parameter int unsigned ALU_CTRL_W  = 3,
  parameter bit          BL_EN       = 1'b1,
  parameter bit          CV_ON_LOGIC = 1'b0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [3:0]            Cond,
  input  logic [1:0]            Op,
  input  logic [5:0]            Funct,
  input  logic [3:0]            Rd,
  input  logic [3:0]            ALUFlags,
  output logic                  PCWrite,
  output logic                  AdrSrc,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic                  RegWrite,
  output logic                  LinkWrite,
  output logic [1:0]            ResultSrc,
  output logic                  ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ImmSrc,
  output logic [1:0]            RegSrc,
  output logic                  Shift,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic [3:0]            FlagReg,
  output logic [3:0]            State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;

  state_t     r_state;
  logic [3:0] r_flags;

  logic [3:0] w_cmd;
  logic       w_cond_ex;
  logic [2:0] w_cmd_alu;
  logic       w_cmd_known;
  logic       w_cmd_arith;
  logic       w_cmd_mov;
  logic       w_is_cmp;
  logic       w_flag_we;
  logic       w_dp_regwrite;
  logic [2:0] w_alu3;
  logic       w_n, w_z, w_c, w_v;

  assign w_cmd = Funct[4:1];
  assign {w_n, w_z, w_c, w_v} = r_flags;

  always_comb begin
    w_cond_ex = 1'b0;
    case (Cond)
      4'b0000: w_cond_ex = w_z;
      4'b0001: w_cond_ex = ~w_z;
      4'b0010: w_cond_ex = w_c;
      4'b0011: w_cond_ex = ~w_c;
      4'b0100: w_cond_ex = w_n;
      4'b0101: w_cond_ex = ~w_n;
      4'b0110: w_cond_ex = w_v;
      4'b0111: w_cond_ex = ~w_v;
      4'b1000: w_cond_ex = w_c & ~w_z;
      4'b1001: w_cond_ex = ~w_c | w_z;
      4'b1010: w_cond_ex = (w_n == w_v);
      4'b1011: w_cond_ex = (w_n != w_v);
      4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
      4'b1101: w_cond_ex = w_z | (w_n != w_v);
      4'b1110: w_cond_ex = 1'b1;
      default: w_cond_ex = 1'b0;
    endcase
  end

  // Unlisted data-processing commands run as ADD but never write registers or flags.
  always_comb begin
    w_cmd_alu   = ALU_ADD;
    w_cmd_known = 1'b0;
    w_cmd_arith = 1'b0;
    w_cmd_mov   = 1'b0;
    case (w_cmd)
      4'b0100: begin w_cmd_known = 1'b1; w_cmd_arith = 1'b1; end
      4'b0010, 4'b1010: begin
        w_cmd_alu = ALU_SUB; w_cmd_known = 1'b1; w_cmd_arith = 1'b1;
      end
      4'b0000: begin w_cmd_alu = ALU_AND; w_cmd_known = 1'b1; end
      4'b1100: begin w_cmd_alu = ALU_ORR; w_cmd_known = 1'b1; end
      4'b0001: begin w_cmd_alu = ALU_EOR; w_cmd_known = 1'b1; end
      4'b1101: begin w_cmd_known = 1'b1; w_cmd_mov = 1'b1; end
      default: ;
    endcase
  end

  assign w_is_cmp      = (w_cmd == 4'b1010);
  assign w_flag_we     = w_cond_ex & w_cmd_known & (Funct[0] | w_is_cmp);
  assign w_dp_regwrite = w_cond_ex & w_cmd_known & ~w_is_cmp;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state <= S_FETCH;
      r_flags <= '0;
    end else begin
      case (r_state)
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          case (Op)
            2'b01:   r_state <= S_MEMADR;
            2'b00:   r_state <= Funct[5] ? S_EXECI : S_EXECR;
            2'b10:   r_state <= S_BRANCH;
            default: r_state <= S_FETCH;
          endcase
        end
        S_MEMADR: r_state <= Funct[0] ? S_MEMRD : S_MEMWR;
        S_MEMRD:  r_state <= S_MEMWB;
        S_EXECR, S_EXECI: begin
          r_state <= S_ALUWB;
          if (w_flag_we) begin
            r_flags[3:2] <= ALUFlags[3:2];
            if (w_cmd_arith)      r_flags[1:0] <= ALUFlags[1:0];
            else if (CV_ON_LOGIC) r_flags[1:0] <= '0;
          end
        end
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    LinkWrite = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ImmSrc    = 2'b00;
    RegSrc    = 2'b00;
    Shift     = 1'b0;
    w_alu3    = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        IRWrite = 1'b1; PCWrite = 1'b1;
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01; ImmSrc = 2'b01;
        w_alu3  = Funct[3] ? ALU_ADD : ALU_SUB;
      end
      S_MEMRD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01; RegWrite = w_cond_ex;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1; MemWrite = w_cond_ex; RegSrc = 2'b10;
      end
      S_EXECR: begin
        w_alu3 = w_cmd_alu; Shift = w_cmd_mov;
      end
      S_EXECI: begin
        ALUSrcB = 2'b01; w_alu3 = w_cmd_alu; Shift = w_cmd_mov;
      end
      S_ALUWB: begin
        RegWrite = w_dp_regwrite;
        PCWrite  = w_dp_regwrite & (Rd == 4'd15);
      end
      S_BRANCH: begin
        RegSrc = 2'b01; ALUSrcB = 2'b01; ImmSrc = 2'b10; ResultSrc = 2'b10;
        PCWrite   = w_cond_ex;
        LinkWrite = w_cond_ex & BL_EN & Funct[4];
      end
      default: ;
    endcase
  end

  assign ALUControl = ALU_CTRL_W'(w_alu3);
  assign FlagReg    = r_flags;
  assign State      = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed scenarios plus random instruction
// streams compared against an instruction-level model of sequencing, writes and flags.
module tb_mc_controller;
  localparam bit BL_EN_P = 1'b1;
  localparam bit CV_ON_LOGIC_P = 1'b0;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [3:0] Cond, Rd, ALUFlags;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, LinkWrite, ALUSrcA, Shift;
  logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic [2:0] ALUControl;
  logic [3:0] FlagReg, State;

  int checks = 0;
  int errors = 0;
  logic [3:0] m_flags;

  mc_controller #(.ALU_CTRL_W(3), .BL_EN(BL_EN_P), .CV_ON_LOGIC(CV_ON_LOGIC_P)) dut (
    .Clock(Clock), .Reset(Reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .LinkWrite(LinkWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .Shift(Shift),
    .ALUControl(ALUControl), .FlagReg(FlagReg), .State(State)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !cf || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // {known, arithmetic, ALU code}
  function automatic logic [4:0] dp_info(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return {2'b11, 3'b000};
      4'b0010: return {2'b11, 3'b001};
      4'b1010: return {2'b11, 3'b001};
      4'b0000: return {2'b10, 3'b010};
      4'b1100: return {2'b10, 3'b011};
      4'b0001: return {2'b10, 3'b100};
      4'b1101: return {2'b10, 3'b000};
      default: return {2'b00, 3'b000};
    endcase
  endfunction

  // Called at a negedge with the DUT in FETCH; returns at the negedge of the next FETCH.
  task automatic run_instr(input logic [3:0] cond, input logic [1:0] op, input logic [5:0] funct,
                           input logic [3:0] rd, input bit fixed, input logic [3:0] fflags);
    int seq[$];
    logic [4:0] info;
    logic [3:0] cmd;
    bit is_ldr, is_str, is_dp, is_br, known, arith, is_cmp, dpw, okc, last;
    logic [5:0] exp_en, got_en;
    logic [3:0] af;
    cmd    = funct[4:1];
    info   = dp_info(cmd);
    known  = info[4];
    arith  = info[3];
    is_cmp = (cmd == 4'b1010);
    dpw    = known && !is_cmp;
    is_ldr = (op == 2'b01) && funct[0];
    is_str = (op == 2'b01) && !funct[0];
    is_dp  = (op == 2'b00);
    is_br  = (op == 2'b10);
    if (is_ldr)      seq = '{0, 1, 2, 3, 4};
    else if (is_str) seq = '{0, 1, 2, 5};
    else if (is_dp)  seq = funct[5] ? '{0, 1, 7, 8} : '{0, 1, 6, 8};
    else if (is_br)  seq = '{0, 1, 9};
    else             seq = '{0, 1};
    Cond = cond; Op = op; Funct = funct; Rd = rd;
    for (int k = 0; k < seq.size(); k++) begin
      last = (k == seq.size() - 1);
      okc  = cond_ok(cond, m_flags);
      checks++;
      if (State !== 4'(seq[k])) begin
        errors++;
        $display("FAIL state op=%b funct=%b k=%0d got %0d exp %0d", op, funct, k, State, seq[k]);
      end
      checks++;
      if (FlagReg !== m_flags) begin
        errors++;
        $display("FAIL flagreg k=%0d got %b exp %b", k, FlagReg, m_flags);
      end
      // {IRWrite, PCWrite, RegWrite, MemWrite, LinkWrite, AdrSrc}
      exp_en[5] = (k == 0);
      exp_en[4] = (k == 0) || (last && is_br && okc) || (last && is_dp && dpw && okc && rd == 4'd15);
      exp_en[3] = last && okc && (is_ldr || (is_dp && dpw));
      exp_en[2] = last && is_str && okc;
      exp_en[1] = last && is_br && okc && BL_EN_P && funct[4];
      exp_en[0] = (is_ldr || is_str) && k == 3;
      got_en = {IRWrite, PCWrite, RegWrite, MemWrite, LinkWrite, AdrSrc};
      checks++;
      if (got_en !== exp_en) begin
        errors++;
        $display("FAIL enables cond=%h op=%b funct=%b rd=%0d k=%0d got %b exp %b",
                 cond, op, funct, rd, k, got_en, exp_en);
      end
      if (k == 2 && (is_dp || op == 2'b01)) begin
        checks++;
        if (is_dp && ALUControl !== info[2:0]) begin
          errors++;
          $display("FAIL alucontrol cmd=%b got %b exp %b", cmd, ALUControl, info[2:0]);
        end else if (!is_dp && ALUControl !== (funct[3] ? 3'b000 : 3'b001)) begin
          errors++;
          $display("FAIL alucontrol_mem U=%b got %b", funct[3], ALUControl);
        end
      end
      af = fixed ? fflags : 4'($urandom);
      ALUFlags = af;
      if (is_dp && k == 2 && okc && known && (funct[0] || is_cmp)) begin
        m_flags[3:2] = af[3:2];
        if (arith)              m_flags[1:0] = af[1:0];
        else if (CV_ON_LOGIC_P) m_flags[1:0] = 2'b00;
      end
      @(negedge Clock);
    end
  endtask

  task automatic test_reset;
    Reset = 1'b0; Cond = 4'hE; Op = 2'b00; Funct = '0; Rd = '0; ALUFlags = 4'hF;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    m_flags = 4'b0000;
    checks++;
    if ({State, FlagReg, IRWrite, PCWrite} !== {4'd0, 4'b0000, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL reset got state=%0d flags=%b irw=%b pcw=%b exp 0 0000 1 1",
               State, FlagReg, IRWrite, PCWrite);
    end
  endtask

  task automatic test_ldr_str;
    run_instr(4'hE, 2'b01, 6'b011001, 4'd3, 1'b0, 4'h0);
    run_instr(4'hE, 2'b01, 6'b011000, 4'd4, 1'b0, 4'h0);
    run_instr(4'hE, 2'b01, 6'b010001, 4'd5, 1'b0, 4'h0);
  endtask

  task automatic test_subs_beq;
    run_instr(4'hE, 2'b00, 6'b000101, 4'd2, 1'b1, 4'b0110);
    checks++;
    if (FlagReg !== 4'b0110) begin
      errors++;
      $display("FAIL subs_flags got %b exp 0110", FlagReg);
    end
    Cond = 4'h0; Op = 2'b10; Funct = 6'b000000;
    @(negedge Clock); @(negedge Clock);
    checks++;
    if (State !== 4'd9 || PCWrite !== 1'b1) begin
      errors++;
      $display("FAIL beq_taken got state=%0d pcw=%b exp 9 1", State, PCWrite);
    end
    @(negedge Clock);
  endtask

  task automatic test_bne_cmp;
    run_instr(4'h1, 2'b10, 6'b010000, 4'd0, 1'b0, 4'h0);
    run_instr(4'hE, 2'b00, 6'b010101, 4'd15, 1'b1, 4'b0100);
    run_instr(4'hE, 2'b00, 6'b111010, 4'd15, 1'b0, 4'h0);
    run_instr(4'hE, 2'b10, 6'b010000, 4'd0, 1'b0, 4'h0);
  endtask

  task automatic test_reset_mid;
    Cond = 4'hE; Op = 2'b01; Funct = 6'b011000; Rd = 4'd1;
    repeat (3) @(negedge Clock);
    checks++;
    if (State !== 4'd5 || MemWrite !== 1'b1) begin
      errors++;
      $display("FAIL memwr_before_reset got state=%0d mw=%b exp 5 1", State, MemWrite);
    end
    Reset = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    m_flags = 4'b0000;
    checks++;
    if (State !== 4'd0 || MemWrite !== 1'b0 || FlagReg !== 4'b0000) begin
      errors++;
      $display("FAIL reset_in_memwr got state=%0d mw=%b flags=%b exp 0 0 0000",
               State, MemWrite, FlagReg);
    end
    Funct = 6'b011001;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    checks++;
    if (State !== 4'd0 || RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_memadr got state=%0d rw=%b exp 0 0", State, RegWrite);
    end
  endtask

  task automatic test_never;
    run_instr(4'hE, 2'b00, 6'b001001, 4'd7, 1'b1, 4'b1011);
    run_instr(4'hF, 2'b00, 6'b101001, 4'd15, 1'b1, 4'b0100);
    checks++;
    if (State !== 4'd0 || FlagReg !== 4'b1011) begin
      errors++;
      $display("FAIL never_cond got state=%0d flags=%b exp 0 1011", State, FlagReg);
    end
  endtask

  task automatic test_random;
    logic [1:0] op;
    logic [3:0] rd, cond;
    for (int i = 0; i < 200; i++) begin
      op   = 2'($urandom);
      cond = (i % 9 == 0) ? 4'hE : 4'($urandom);
      rd   = (op == 2'b01) ? 4'($urandom_range(14, 0)) : 4'($urandom);
      run_instr(cond, op, 6'($urandom), rd, 1'b0, 4'h0);
    end
  endtask

  initial begin
    test_reset();
    test_ldr_str();
    test_subs_beq();
    test_bne_cmp();
    test_reset_mid();
    test_never();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
